// File: rtl/icache_burst.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// icache_burst
// Direct-mapped, read-only instruction cache sitting between the fetch stage
// and an AXI read channel. Hits return one cycle after acceptance. A miss
// refills the whole line with a single INCR burst and returns the requested
// word once the last beat has arrived. Uncached fetches bypass the arrays
// as single-beat reads.
//
// Parameters
//   LINE_WORDS  words per line (power of 2, 2..16)
//   SETS        number of lines (power of 2, 2..256)
//   AXI_ID      constant driven on arid
//
// Ports
//   aclk, aresetn              clock, asynchronous active-low reset
//   bus_en/bus_addr/bus_cached fetch request (held while icache_stall)
//   bus_stall                  pipeline stall, blocks acceptance
//   inv_all                    one-cycle pulse, clears every valid bit
//   bus_rdata/bus_rvalid/bus_rerr   fetch response (registered)
//   icache_stall               request outstanding and not completing
//   ar*                        AXI read address channel (master side)
//   r*                         AXI read data channel (rready tied high)
// -----------------------------------------------------------------------------
module icache_burst #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64,
  parameter int AXI_ID     = 0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        bus_en,
  input  logic [31:0] bus_addr,
  input  logic        bus_cached,
  input  logic        bus_stall,
  input  logic        inv_all,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  output logic        bus_rerr,
  output logic        icache_stall,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int OFF  = $clog2(LINE_WORDS);
  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = 32 - OFF - IDX - 2;

  localparam logic [3:0] ARLEN_LINE = 4'(LINE_WORDS - 1);
  localparam logic [3:0] ARID_C     = 4'(AXI_ID);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_AR     = 3'd2,
    ST_REFILL = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // State and storage
  // ---------------------------------------------------------------------------
  state_t              state_r;
  logic [SETS-1:0]     valid_r;
  logic [TAGW-1:0]     tag_r  [SETS];
  logic [31:0]         data_r [SETS][LINE_WORDS];

  logic [TAGW-1:0]     req_tag_r;
  logic [IDX-1:0]      req_idx_r;
  logic [OFF-1:0]      req_off_r;
  logic                req_cached_r;
  logic                lookup_hit_r;
  logic [OFF-1:0]      beat_r;
  logic                err_r;
  logic                inv_pend_r;

  logic [31:0]         bus_rdata_r;
  logic                bus_rvalid_r;
  logic                bus_rerr_r;
  logic                icache_stall_r;
  logic                arvalid_r;
  logic [31:0]         araddr_r;
  logic [3:0]          arlen_r;

  // ---------------------------------------------------------------------------
  // Incoming-request decode. The hit is evaluated at acceptance so the
  // response can leave a register in the LOOKUP cycle. An inv_all in the
  // acceptance cycle clears valid before LOOKUP, so it forces a miss here.
  // ---------------------------------------------------------------------------
  logic [OFF-1:0]      acc_off_s;
  logic [IDX-1:0]      acc_idx_s;
  logic [TAGW-1:0]     acc_tag_s;
  logic                acc_hit_s;
  logic [31:0]         acc_word_s;
  logic                accept_s;
  logic                beat_err_s;
  logic                refill_beat_s;
  logic                refill_last_s;
  logic                line_ok_s;
  logic                capture_s;
  logic                unused_s;

  assign acc_off_s  = bus_addr[OFF+1:2];
  assign acc_idx_s  = bus_addr[OFF+IDX+1:OFF+2];
  assign acc_tag_s  = bus_addr[31:OFF+IDX+2];
  assign acc_hit_s  = valid_r[acc_idx_s] & (tag_r[acc_idx_s] == acc_tag_s) & ~inv_all;
  assign acc_word_s = data_r[acc_idx_s][acc_off_s];

  assign beat_err_s    = (rresp != 2'b00);
  assign refill_beat_s = (state_r == ST_REFILL) & rvalid;
  assign refill_last_s = refill_beat_s & rlast;
  // The line only becomes valid if every beat was OKAY and no invalidate
  // landed while the burst was in flight.
  assign line_ok_s     = req_cached_r & ~err_r & ~beat_err_s & ~inv_pend_r;

  // rid and the byte-lane address bits carry no information for this block.
  assign unused_s = ^{rid, bus_addr[1:0]};

  // Acceptance: IDLE always takes a request, LOOKUP only on its hit cycle
  always_comb begin
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE:   accept_s = bus_en & ~bus_stall;
      ST_LOOKUP: accept_s = bus_en & ~bus_stall & lookup_hit_r;
      default:   accept_s = 1'b0;
    endcase
  end

  // Response capture: requested word for cached refills, the only beat otherwise
  always_comb begin
    capture_s = 1'b0;
    if (req_cached_r) begin
      capture_s = (beat_r == req_off_r);
    end else begin
      capture_s = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered bus and AXI outputs
  // ---------------------------------------------------------------------------
  // Main controller: acceptance, lookup, AR issue, refill tracking, response
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r        <= ST_IDLE;
      req_tag_r      <= {TAGW{1'b0}};
      req_idx_r      <= {IDX{1'b0}};
      req_off_r      <= {OFF{1'b0}};
      req_cached_r   <= 1'b0;
      lookup_hit_r   <= 1'b0;
      beat_r         <= {OFF{1'b0}};
      err_r          <= 1'b0;
      inv_pend_r     <= 1'b0;
      bus_rdata_r    <= 32'h0000_0000;
      bus_rvalid_r   <= 1'b0;
      bus_rerr_r     <= 1'b0;
      icache_stall_r <= 1'b0;
      arvalid_r      <= 1'b0;
      araddr_r       <= 32'h0000_0000;
      arlen_r        <= 4'h0;
    end else begin
      // Response strobes are single-cycle unless re-armed below.
      bus_rvalid_r <= 1'b0;
      bus_rerr_r   <= 1'b0;

      if (accept_s) begin
        req_tag_r    <= acc_tag_s;
        req_idx_r    <= acc_idx_s;
        req_off_r    <= acc_off_s;
        req_cached_r <= bus_cached;
        if (bus_cached) begin
          state_r        <= ST_LOOKUP;
          lookup_hit_r   <= acc_hit_s;
          bus_rvalid_r   <= acc_hit_s;
          bus_rdata_r    <= acc_word_s;
          icache_stall_r <= ~acc_hit_s;
        end else begin
          state_r        <= ST_AR;
          lookup_hit_r   <= 1'b0;
          arvalid_r      <= 1'b1;
          araddr_r       <= {bus_addr[31:2], 2'b00};
          arlen_r        <= 4'h0;
          icache_stall_r <= 1'b1;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            icache_stall_r <= 1'b0;
          end
          ST_LOOKUP: begin
            if (lookup_hit_r) begin
              state_r        <= ST_IDLE;
              icache_stall_r <= 1'b0;
            end else begin
              state_r        <= ST_AR;
              arvalid_r      <= 1'b1;
              araddr_r       <= {req_tag_r, req_idx_r, {(OFF+2){1'b0}}};
              arlen_r        <= ARLEN_LINE;
              icache_stall_r <= 1'b1;
            end
          end
          ST_AR: begin
            if (arready) begin
              state_r   <= ST_REFILL;
              arvalid_r <= 1'b0;
              beat_r    <= {OFF{1'b0}};
              err_r     <= 1'b0;
            end
          end
          ST_REFILL: begin
            if (rvalid) begin
              beat_r <= beat_r + OFF'(1'b1);
              err_r  <= err_r | beat_err_s;
              if (capture_s) begin
                bus_rdata_r <= rdata;
              end
              if (rlast) begin
                state_r        <= ST_RESP;
                bus_rvalid_r   <= 1'b1;
                bus_rerr_r     <= err_r | beat_err_s;
                icache_stall_r <= 1'b0;
              end
            end
          end
          ST_RESP: begin
            state_r        <= ST_IDLE;
            icache_stall_r <= 1'b0;
          end
          default: begin
            state_r        <= ST_IDLE;
            arvalid_r      <= 1'b0;
            icache_stall_r <= 1'b0;
          end
        endcase
      end

      // An invalidate during the burst must keep this line from going valid.
      if (refill_last_s) begin
        inv_pend_r <= 1'b0;
      end else if (inv_all & ((state_r == ST_AR) | (state_r == ST_REFILL))) begin
        inv_pend_r <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arrays
  // ---------------------------------------------------------------------------
  // Line storage: each cached beat lands in data, the closing beat writes tag
  always_ff @(posedge aclk) begin
    if (refill_beat_s & req_cached_r) begin
      data_r[req_idx_r][beat_r] <= rdata;
      if (rlast) begin
        tag_r[req_idx_r] <= req_tag_r;
      end
    end
  end

  // Valid bits: invalidate-all has priority over setting the refilled line
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      valid_r <= {SETS{1'b0}};
    end else if (inv_all) begin
      valid_r <= {SETS{1'b0}};
    end else if (refill_last_s & line_ok_s) begin
      valid_r[req_idx_r] <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus_rdata    = bus_rdata_r;
  assign bus_rvalid   = bus_rvalid_r;
  assign bus_rerr     = bus_rerr_r;
  assign icache_stall = icache_stall_r;
  assign arid         = ARID_C;
  assign araddr       = araddr_r;
  assign arlen        = arlen_r;
  assign arsize       = 3'b010;
  assign arburst      = 2'b01;
  assign arvalid      = arvalid_r;
  assign rready       = 1'b1;

endmodule

// File: tb/tb_icache_burst.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_icache_burst
// Directed self-checking bench for icache_burst (LINE_WORDS=4, SETS=64).
// The bench plays the AXI slave; every expected value is hand-computed from
// the address map: off = addr[3:2], idx = addr[9:4], tag = addr[31:10].
// -----------------------------------------------------------------------------
module tb_icache_burst;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        bus_en = 1'b0;
  logic [31:0] bus_addr = 32'h0000_0000;
  logic        bus_cached = 1'b0;
  logic        bus_stall = 1'b0;
  logic        inv_all = 1'b0;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic        bus_rerr;
  logic        icache_stall;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = 4'h0;
  logic [31:0] rdata = 32'h0000_0000;
  logic [1:0]  rresp = 2'b00;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;

  int n_cmp = 0;
  int n_err = 0;

  icache_burst #(.LINE_WORDS(4), .SETS(64), .AXI_ID(0)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .bus_en(bus_en), .bus_addr(bus_addr), .bus_cached(bus_cached),
    .bus_stall(bus_stall), .inv_all(inv_all),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .bus_rerr(bus_rerr),
    .icache_stall(icache_stall),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".arvalid"}, {31'd0, arvalid}, 32'd0);
    chk({tag, ".rvalid"},  {31'd0, bus_rvalid}, 32'd0);
    chk({tag, ".rerr"},    {31'd0, bus_rerr}, 32'd0);
    chk({tag, ".rdata"},   bus_rdata, 32'h0000_0000);
    chk({tag, ".stall"},   {31'd0, icache_stall}, 32'd0);
  endtask

  // Cached fetch expected to hit: data one cycle after acceptance.
  task automatic hit(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    bus_en = 1'b1; bus_addr = addr; bus_cached = 1'b1;
    step();
    chk({tag, ".rvalid"},  {31'd0, bus_rvalid}, 32'd1);
    chk({tag, ".rdata"},   bus_rdata, exp);
    chk({tag, ".stall"},   {31'd0, icache_stall}, 32'd0);
    chk({tag, ".arvalid"}, {31'd0, arvalid}, 32'd0);
    bus_en = 1'b0;
    step();
    chk({tag, ".rvalid_off"}, {31'd0, bus_rvalid}, 32'd0);
  endtask

  // Fetch expected to go to AXI; the bench acts as the slave.
  task automatic miss(input logic [31:0] addr, input logic cached,
                      input logic [31:0] exp_araddr, input logic [3:0] exp_arlen,
                      input logic [31:0] base, input int err_beat, input int inv_beat,
                      input logic [31:0] exp_data, input logic exp_err, input string tag);
    int waited;
    bus_en = 1'b1; bus_addr = addr; bus_cached = cached;
    step();
    chk({tag, ".rvalid_acc"}, {31'd0, bus_rvalid}, 32'd0);
    chk({tag, ".stall_acc"},  {31'd0, icache_stall}, 32'd1);
    waited = 0;
    while (!arvalid && waited < 20) begin
      step();
      waited++;
    end
    chk({tag, ".ar_latency"}, waited, cached ? 32'd1 : 32'd0);
    chk({tag, ".araddr"}, araddr, exp_araddr);
    chk({tag, ".arlen"},  {28'd0, arlen}, {28'd0, exp_arlen});
    chk({tag, ".arid"},   {28'd0, arid}, 32'd0);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk({tag, ".arvalid_done"}, {31'd0, arvalid}, 32'd0);
    for (int i = 0; i <= int'(exp_arlen); i++) begin
      rvalid  = 1'b1;
      rdata   = base + 32'(i);
      rresp   = (i == err_beat) ? 2'b10 : 2'b00;
      rlast   = (i == int'(exp_arlen));
      inv_all = (i == inv_beat);
      step();
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; inv_all = 1'b0;
    chk({tag, ".rvalid"}, {31'd0, bus_rvalid}, 32'd1);
    chk({tag, ".rdata"},  bus_rdata, exp_data);
    chk({tag, ".rerr"},   {31'd0, bus_rerr}, {31'd0, exp_err});
    chk({tag, ".stall"},  {31'd0, icache_stall}, 32'd0);
    bus_en = 1'b0;
    step();
    chk({tag, ".rvalid_off"}, {31'd0, bus_rvalid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;

    // Reset values
    aresetn = 1'b0;
    repeat (3) step();
    chk_reset_outputs("reset");
    chk("reset.rready",  {31'd0, rready}, 32'd1);
    chk("reset.arsize",  {29'd0, arsize}, 32'd2);
    chk("reset.arburst", {30'd0, arburst}, 32'd1);
    aresetn = 1'b1;
    step();

    // Cold miss on word 2 of line 0x1000, then hit on word 0
    miss(32'h0000_1008, 1'b1, 32'h0000_1000, 4'd3, 32'h0000_00A0, -1, -1,
         32'h0000_00A2, 1'b0, "cold");
    hit(32'h0000_1000, 32'h0000_00A0, "refetch");

    // Back-to-back hits over the whole line, one word per cycle
    bus_en = 1'b1; bus_cached = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_addr = 32'h0000_1000 + 32'(4 * i);
      step();
      chk("b2b.rvalid",  {31'd0, bus_rvalid}, 32'd1);
      chk("b2b.rdata",   bus_rdata, 32'h0000_00A0 + 32'(i));
      chk("b2b.arvalid", {31'd0, arvalid}, 32'd0);
    end
    bus_en = 1'b0;
    step();
    chk("b2b.rvalid_off", {31'd0, bus_rvalid}, 32'd0);

    // Conflict: 0x1400 maps to the same set as 0x1000
    miss(32'h0000_1400, 1'b1, 32'h0000_1400, 4'd3, 32'h0000_00B0, -1, -1,
         32'h0000_00B0, 1'b0, "conflict_a");
    miss(32'h0000_1000, 1'b1, 32'h0000_1000, 4'd3, 32'h0000_00C0, -1, -1,
         32'h0000_00C0, 1'b0, "conflict_b");
    hit(32'h0000_1004, 32'h0000_00C1, "conflict_hit");

    // Uncached: single beat, new AR each time, cache untouched
    miss(32'h1FC0_0004, 1'b0, 32'h1FC0_0004, 4'd0, 32'h0000_00D0, -1, -1,
         32'h0000_00D0, 1'b0, "unc_a");
    miss(32'h1FC0_0004, 1'b0, 32'h1FC0_0004, 4'd0, 32'h0000_00D8, -1, -1,
         32'h0000_00D8, 1'b0, "unc_b");
    miss(32'h0000_1008, 1'b0, 32'h0000_1008, 4'd0, 32'h0000_00EE, -1, -1,
         32'h0000_00EE, 1'b0, "unc_same_line");
    hit(32'h0000_1008, 32'h0000_00C2, "unc_cache_kept");

    // Error on beat 1: response flagged, line left invalid
    miss(32'h0000_2010, 1'b1, 32'h0000_2010, 4'd3, 32'h0000_00E0, 1, -1,
         32'h0000_00E0, 1'b1, "err");
    miss(32'h0000_2010, 1'b1, 32'h0000_2010, 4'd3, 32'h0000_00F0, -1, -1,
         32'h0000_00F0, 1'b0, "err_refetch");
    hit(32'h0000_2014, 32'h0000_00F1, "err_recovered");

    // inv_all during refill: data still returned, line and others invalid
    miss(32'h0000_3020, 1'b1, 32'h0000_3020, 4'd3, 32'h0000_0050, -1, 1,
         32'h0000_0050, 1'b0, "inv_refill");
    miss(32'h0000_2014, 1'b1, 32'h0000_2010, 4'd3, 32'h0000_0070, -1, -1,
         32'h0000_0071, 1'b0, "inv_other");
    miss(32'h0000_3020, 1'b1, 32'h0000_3020, 4'd3, 32'h0000_0060, -1, -1,
         32'h0000_0060, 1'b0, "inv_refetch");

    // inv_all in the LOOKUP hit cycle: hit returns, then the line misses
    bus_en = 1'b1; bus_addr = 32'h0000_3020; bus_cached = 1'b1;
    step();
    inv_all = 1'b1;
    chk("inv_hit.rvalid", {31'd0, bus_rvalid}, 32'd1);
    chk("inv_hit.rdata",  bus_rdata, 32'h0000_0060);
    bus_en = 1'b0;
    step();
    inv_all = 1'b0;
    miss(32'h0000_3020, 1'b1, 32'h0000_3020, 4'd3, 32'h0000_0090, -1, -1,
         32'h0000_0090, 1'b0, "inv_hit_after");

    // Reset in the middle of a burst
    bus_en = 1'b1; bus_addr = 32'h0000_4000; bus_cached = 1'b1;
    step();
    waited = 0;
    while (!arvalid && waited < 20) begin
      step();
      waited++;
    end
    chk("midrst.ar_latency", waited, 32'd1);
    arready = 1'b1;
    step();
    arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1; rdata = 32'h0000_0040 + 32'(i);
      step();
    end
    rvalid = 1'b0;
    bus_en = 1'b0;
    aresetn = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    step();
    step();
    aresetn = 1'b1;
    step();
    chk_reset_outputs("midrst_release");
    // Reset cleared every valid bit, so a previously cached line misses.
    miss(32'h0000_1000, 1'b1, 32'h0000_1000, 4'd3, 32'h0000_0030, -1, -1,
         32'h0000_0030, 1'b0, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
